led_select_ctrl: RTL and testbench
==================================

LED_SELECT_CTRL -- requirements
Module: led_select_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 12, sets the number of consecutive stable synced samples needed to accept a key level change (20 ms at 600 Hz).
REQ-002 Parameter SCAN_PERIOD, default 600, sets the number of clock cycles per auto-scan step (1 s at 600 Hz).
REQ-003 Port clk, input, 1 bit, is the single system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the asynchronous active-low reset.
REQ-005 Port key_next_n, input, 1 bit, is the raw asynchronous "next LED" push-button; low means pressed.
REQ-006 Port key_prev_n, input, 1 bit, is the raw asynchronous "previous LED" push-button; low means pressed.
REQ-007 Port auto_en, input, 1 bit, selects the mode: high is auto-scan, low is manual.
REQ-008 Port led_select, output, 4 bits, is the index of the selected LED and feeds the heartbeat LED driver's led_select input; its range is 0..7.
REQ-009 Port sel_changed, output, 1 bit, is a one-cycle pulse marking each change of led_select.

Function
REQ-010 Each key SHALL pass through a two-flop synchronizer before any other logic.
- The synchronizer flops reset to 1.
REQ-011 Per-key debounce: the debounced level SHALL take the synced value once the synced value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- Any matching sample clears the counter.
REQ-012 A press pulse SHALL be generated for exactly one cycle on each debounced 1->0 transition.
- A key release generates no pulse.
REQ-013 Latency: with a key held low from cycle 0, led_select SHALL change on edge DEBOUNCE_CYCLES+3.
REQ-014 The state machine SHALL have two states, MANUAL and AUTO.
- MANUAL->AUTO when registered auto_en=1.
- AUTO->MANUAL when auto_en=0.
- Transitions take effect one cycle after auto_en changes.
REQ-015 In MANUAL, a next press SHALL increment led_select and a prev press SHALL decrement it, both modulo 8.
- Wrap 7->0 on next; wrap 0->7 on prev.
REQ-016 If next and prev press pulses occur in the same cycle, led_select SHALL be unchanged and sel_changed SHALL stay 0.
REQ-017 In AUTO, scan_cnt SHALL count 0..SCAN_PERIOD-1.
- At SCAN_PERIOD-1, led_select increments modulo 8 and scan_cnt returns to 0.
- Key press pulses are discarded.
REQ-018 scan_cnt SHALL be cleared on entry to AUTO; led_select SHALL keep its value across mode changes.
REQ-019 sel_changed SHALL be asserted in the same cycle that led_select takes its new value, and only when the value actually differs.
REQ-020 led_select[3] SHALL always be 0.

Reset
REQ-021 While rst_n=0, the block SHALL hold:
- led_select=0 and sel_changed=0;
- debounced levels=1 and synchronizers=1;
- all counters=0;
- state=MANUAL.
REQ-022 Reset asserted mid-debounce or mid-scan SHALL abort the operation with no pulse or update.
- A key held low through reset release registers as a press DEBOUNCE_CYCLES+3 cycles after release.

Configuration
REQ-023 Macro LED_SEL_AUTO_SCAN_EN defined: the AUTO state and scan counter are compiled in, per REQ-014..REQ-018.
REQ-024 Macro LED_SEL_AUTO_SCAN_EN undefined: there is no AUTO state and no scan counter, auto_en is ignored, and the block is permanently MANUAL.

Structure
REQ-025 A shared package led_pkg SHALL hold:
- LED_COUNT=8;
- SEL_W=4;
- the default DEBOUNCE_CYCLES and SCAN_PERIOD;
- the state enum (MANUAL, AUTO).
REQ-026 Sub-module key_debounce SHALL contain the synchronizer, debounce counter and press-pulse generator.
- It is instantiated twice, once per key.

Verification
REQ-027 Reset then key_next_n low held for 20 cycles -> led_select goes 0->1 at edge 15 with a single sel_changed pulse, and no further change while the key stays held.
REQ-028 key_next_n glitching low for 11 cycles then high -> led_select stays 0 and sel_changed never asserts.
REQ-029 led_select=7 then a next press -> 0; led_select=0 then a prev press -> 7; each with one sel_changed pulse.
REQ-030 Both keys go low on the same cycle and are held -> led_select unchanged and no sel_changed.
REQ-031 With the macro defined, auto_en=1 for 1800 cycles starting at led_select=6 -> values 7, 0, 1 at 600-cycle spacing, with key presses ignored; then auto_en=0 -> value held at 1.
REQ-032 rst_n pulsed low at debounce count 10 while a key is held -> led_select=0 immediately, and a press registers 15 cycles after rst_n rises.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED selector: sizes, default timing and the
// mode state type. Used by key_debounce and led_select_ctrl.
`timescale 1ns/1ps
package led_pkg;

    localparam int LED_COUNT           = 8;
    localparam int SEL_W               = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 12;
    localparam int DEF_SCAN_PERIOD     = 600;

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } led_state_e;

    // Next LED index, modulo 8; the top bit of the index stays 0.
    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] v);
        return {1'b0, v[2:0] + 3'd1};
    endfunction

    // Previous LED index, modulo 8; the top bit of the index stays 0.
    function automatic logic [SEL_W-1:0] sel_dec(input logic [SEL_W-1:0] v);
        return {1'b0, v[2:0] - 3'd1};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchronizer, stable-level debounce
// counter and a one-cycle press pulse on each debounced 1->0 edge.
`timescale 1ns/1ps
module key_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the raw key into the clock domain; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = {CNT_W{1'b0}};
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d   = sync2_q;
                cnt_d   = {CNT_W{1'b0}};
                press_d = ~sync2_q;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Debounced level, counter and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q   <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
            press_q <= 1'b0;
        end else begin
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_select_ctrl.sv
// LED selector: next/prev buttons step the selected LED index (0..7) in
// manual mode; optional auto-scan mode steps it every SCAN_PERIOD cycles.
// Build option: define LED_SEL_AUTO_SCAN_EN to include the AUTO mode and
// scan counter; without it the block is always manual and auto_en is ignored.
`timescale 1ns/1ps
module led_select_ctrl
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SCAN_PERIOD     = DEF_SCAN_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_next_n,
    input  logic             key_prev_n,
    input  logic             auto_en,
    output logic [SEL_W-1:0] led_select,
    output logic             sel_changed
);

    logic             press_next_s;
    logic             press_prev_s;
    logic             scan_tick_s;
    led_state_e       state_s;
    logic [SEL_W-1:0] led_q;
    logic [SEL_W-1:0] led_d;
    logic             chg_q;
    logic             chg_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_next_n),
        .press (press_next_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_prev_n),
        .press (press_prev_s)
    );

`ifdef LED_SEL_AUTO_SCAN_EN
    localparam int               SCAN_W    = $clog2(SCAN_PERIOD + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

    logic              auto_en_q;
    led_state_e        state_q;
    led_state_e        state_d;
    logic [SCAN_W-1:0] scan_q;
    logic [SCAN_W-1:0] scan_d;

    // Mode state register; auto_en is registered before it steers the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_en_q <= 1'b0;
            state_q   <= MANUAL;
        end else begin
            auto_en_q <= auto_en;
            state_q   <= state_d;
        end
    end

    // Mode next-state: follow the registered auto_en.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MANUAL: begin
                if (auto_en_q) state_d = AUTO;
                else           state_d = MANUAL;
            end
            AUTO: begin
                if (!auto_en_q) state_d = MANUAL;
                else            state_d = AUTO;
            end
            default: state_d = MANUAL;
        endcase
    end

    // Scan counter runs only in AUTO, so it restarts from 0 on every entry.
    always_comb begin
        scan_d      = {SCAN_W{1'b0}};
        scan_tick_s = 1'b0;
        if (state_q == AUTO) begin
            if (scan_q == SCAN_LAST) begin
                scan_d      = {SCAN_W{1'b0}};
                scan_tick_s = 1'b1;
            end else begin
                scan_d      = scan_q + SCAN_W'(1);
                scan_tick_s = 1'b0;
            end
        end else begin
            scan_d      = {SCAN_W{1'b0}};
            scan_tick_s = 1'b0;
        end
    end

    // Scan counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= {SCAN_W{1'b0}};
        end else begin
            scan_q <= scan_d;
        end
    end

    assign state_s = state_q;
`else
    logic auto_en_unused_s;
    localparam int SCAN_PERIOD_UNUSED = SCAN_PERIOD;

    assign auto_en_unused_s = auto_en;
    assign scan_tick_s      = 1'b0;
    assign state_s          = MANUAL;
`endif

    // Output decode: choose the next LED index and flag a real change.
    always_comb begin
        led_d = led_q;
        chg_d = 1'b0;
        case (state_s)
            MANUAL: begin
                if (press_next_s && !press_prev_s) begin
                    led_d = sel_inc(led_q);
                    chg_d = 1'b1;
                end else if (press_prev_s && !press_next_s) begin
                    led_d = sel_dec(led_q);
                    chg_d = 1'b1;
                end else begin
                    led_d = led_q;
                    chg_d = 1'b0;
                end
            end
            AUTO: begin
                if (scan_tick_s) begin
                    led_d = sel_inc(led_q);
                    chg_d = 1'b1;
                end else begin
                    led_d = led_q;
                    chg_d = 1'b0;
                end
            end
            default: begin
                led_d = led_q;
                chg_d = 1'b0;
            end
        endcase
    end

    // Registered LED index and change pulse, so both move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= {SEL_W{1'b0}};
            chg_q <= 1'b0;
        end else begin
            led_q <= led_d;
            chg_q <= chg_d;
        end
    end

    assign led_select  = led_q;
    assign sel_changed = chg_q;

endmodule

// File: tb/tb_led_select_ctrl.sv
// Self-checking bench for led_select_ctrl: directed scenarios plus random
// key/mode/reset activity, all compared every cycle against a reference
// model that works on raw key samples and event times.
`timescale 1ns/1ps
module tb_led_select_ctrl;

    localparam int DEB  = 12;
    localparam int SCAN = 600;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_next_n;
    logic       key_prev_n;
    logic       auto_en;
    logic [3:0] led_select;
    logic       sel_changed;

    always #5 clk = ~clk;

    led_select_ctrl #(.DEBOUNCE_CYCLES(DEB), .SCAN_PERIOD(SCAN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_next_n  (key_next_n),
        .key_prev_n  (key_prev_n),
        .auto_en     (auto_en),
        .led_select  (led_select),
        .sel_changed (sel_changed)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_led;
    bit m_chg;
    int edge_no = 0;
    bit deb_n, deb_p;
    int run_n, run_p;
    int due_n, due_p;
    bit ae_h1, ae_h2;
    int auto_edges;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led = 0; m_chg = 1'b0;
        deb_n = 1'b1; deb_p = 1'b1;
        run_n = 0; run_p = 0;
        due_n = -1; due_p = -1;
        ae_h1 = 1'b0; ae_h2 = 1'b0;
        auto_edges = 0;
    endtask

    // A key level is accepted after DEB consecutive differing raw samples;
    // an accepted press moves the selection 3 edges after its last sample.
    task automatic model_key(input bit raw, inout bit deb, inout int run, inout int due);
        if (raw != deb) begin
            run++;
            if (run == DEB) begin
                deb = raw;
                run = 0;
                if (raw == 1'b0) due = edge_no + 3;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic step();
        bit pn, pp;
        bit in_auto;
        @(posedge clk);
        edge_no++;
        m_chg = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            pn = (due_n == edge_no);
            pp = (due_p == edge_no);
            in_auto = 1'b0;
`ifdef LED_SEL_AUTO_SCAN_EN
            in_auto = ae_h2;
            ae_h2 = ae_h1;
            ae_h1 = auto_en;
            if (in_auto) begin
                auto_edges++;
                if (auto_edges % SCAN == 0) begin
                    m_led = (m_led + 1) % 8;
                    m_chg = 1'b1;
                end
            end else begin
                auto_edges = 0;
            end
`endif
            if (!in_auto) begin
                if (pn && !pp) begin
                    m_led = (m_led + 1) % 8; m_chg = 1'b1;
                end else if (pp && !pn) begin
                    m_led = (m_led + 7) % 8; m_chg = 1'b1;
                end
            end
            model_key(key_next_n, deb_n, run_n, due_n);
            model_key(key_prev_n, deb_p, run_p, due_p);
        end
        #1;
        check_val("led_select", led_select, m_led);
        check_val("sel_changed", sel_changed, m_chg);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_key(input bit is_next, output int pulses);
        pulses = 0;
        if (is_next) key_next_n = 1'b0;
        else         key_prev_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (sel_changed) pulses++;
        end
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (sel_changed) pulses++;
        end
    endtask

    initial begin
        int e0, chg_edge, pulses, len;
        logic [3:0] vals[$];
        model_reset();
        rst_n = 1'b0; key_next_n = 1'b1; key_prev_n = 1'b1; auto_en = 1'b0;
        run_cycles(3);
        check_val("reset_led", led_select, 0);
        rst_n = 1'b1;
        run_cycles(4);

        // Held next key: single change 15 edges after it goes low
        key_next_n = 1'b0; e0 = edge_no; chg_edge = -1; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sel_changed) begin pulses++; chg_edge = edge_no; end
        end
        check_val("hold_latency", chg_edge - e0, 15);
        check_val("hold_pulses", pulses, 1);
        check_val("hold_led", led_select, 1);
        key_next_n = 1'b1;
        run_cycles(16);

        // 11-cycle glitch is rejected
        key_next_n = 1'b0; pulses = 0;
        for (int i = 0; i < 11; i++) begin step(); if (sel_changed) pulses++; end
        key_next_n = 1'b1;
        for (int i = 0; i < 20; i++) begin step(); if (sel_changed) pulses++; end
        check_val("glitch_pulses", pulses, 0);
        check_val("glitch_led", led_select, 1);

        // Wrap-around in both directions
        for (int i = 0; i < 6; i++) press_key(1'b1, pulses);
        check_val("reach7_led", led_select, 7);
        press_key(1'b1, pulses);
        check_val("wrap_next_led", led_select, 0);
        check_val("wrap_next_pulses", pulses, 1);
        press_key(1'b0, pulses);
        check_val("wrap_prev_led", led_select, 7);
        check_val("wrap_prev_pulses", pulses, 1);

        // Simultaneous presses cancel
        key_next_n = 1'b0; key_prev_n = 1'b0; pulses = 0;
        for (int i = 0; i < 20; i++) begin step(); if (sel_changed) pulses++; end
        key_next_n = 1'b1; key_prev_n = 1'b1;
        for (int i = 0; i < 16; i++) begin step(); if (sel_changed) pulses++; end
        check_val("both_pulses", pulses, 0);
        check_val("both_led", led_select, 7);

        // Reset mid-debounce, key held through release
        key_next_n = 1'b0;
        run_cycles(12);
        rst_n = 1'b0;
        #1;
        check_val("async_reset_led", led_select, 0);
        check_val("async_reset_chg", sel_changed, 0);
        run_cycles(3);
        rst_n = 1'b1; e0 = edge_no; chg_edge = -1; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sel_changed) begin pulses++; chg_edge = edge_no; end
        end
        check_val("post_reset_latency", chg_edge - e0, 15);
        check_val("post_reset_led", led_select, 1);
        key_next_n = 1'b1;
        run_cycles(16);

`ifdef LED_SEL_AUTO_SCAN_EN
        // Auto-scan from 6: 7, 0, 1 at 600-cycle spacing, presses ignored
        for (int i = 0; i < 5; i++) press_key(1'b1, pulses);
        check_val("pre_auto_led", led_select, 6);
        auto_en = 1'b1;
        for (int i = 0; i < 1810; i++) begin
            key_next_n = !(i >= 200 && i < 260);
            key_prev_n = !(i >= 700 && i < 760);
            step();
            if (sel_changed) vals.push_back(led_select);
        end
        key_next_n = 1'b1; key_prev_n = 1'b1;
        check_val("auto_count", vals.size(), 3);
        if (vals.size() >= 3) begin
            check_val("auto_v0", vals[0], 7);
            check_val("auto_v1", vals[1], 0);
            check_val("auto_v2", vals[2], 1);
        end
        auto_en = 1'b0;
        run_cycles(50);
        check_val("auto_exit_led", led_select, 1);
`else
        // auto_en has no effect: presses still work, no scanning
        auto_en = 1'b1;
        press_key(1'b1, pulses);
        check_val("noauto_press_led", led_select, 2);
        run_cycles(700);
        check_val("noauto_hold_led", led_select, 2);
        auto_en = 1'b0;
`endif

        // Random key, mode and reset activity
        for (int s = 0; s < 200; s++) begin
            key_next_n = 1'($urandom_range(0, 1));
            key_prev_n = 1'($urandom_range(0, 1));
            auto_en    = 1'($urandom_range(0, 1));
            rst_n      = ($urandom_range(0, 24) != 0);
            len        = rst_n ? $urandom_range(1, 30) : $urandom_range(1, 3);
            run_cycles(len);
        end
        rst_n = 1'b1;
        run_cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
